// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, imem request handshake, one-entry skid buffer and IF/ID register.
// Optional misaligned-redirect halt is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o,
  output logic [6:0]  if_id_opcode_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {FETCH, DROP, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_pc_q, drop_pc_d;
  logic        halt_pend_q, halt_pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] pend_instr_q, pend_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;

  logic [31:0] tgt_pc;
  logic        tgt_misaligned;
  logic        accept;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt_pc         = redirect_pc_i;
  assign tgt_misaligned = |redirect_pc_i[1:0];
  assign misalign_o     = (state_q == HALT);
`else
  assign tgt_pc         = redirect_pc_i & 32'hFFFF_FFFC;
  assign tgt_misaligned = 1'b0;
  assign misalign_o     = 1'b0;
`endif

  // DROP keeps the abandoned request alive so the memory sees a clean handshake.
  assign imem_req_o  = ((state_q == FETCH) && !pend_valid_q) || (state_q == DROP);
  assign imem_addr_o = (state_q == DROP) ? drop_pc_q : pc_q;
  assign accept      = imem_req_o && imem_ack_i;

  assign if_id_valid_o  = ifid_valid_q;
  assign if_id_pc_o     = ifid_pc_q;
  assign if_id_instr_o  = ifid_instr_q;
  assign if_id_opcode_o = ifid_instr_q[6:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_pc_d    = drop_pc_q;
    halt_pend_d  = halt_pend_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    pend_instr_d = pend_instr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;

    if (redirect_i) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      pend_valid_d = 1'b0;
      pc_d         = tgt_pc;
      case (state_q)
        FETCH: begin
          if (imem_req_o && !imem_ack_i) begin
            state_d     = DROP;
            drop_pc_d   = pc_q;
            halt_pend_d = tgt_misaligned;
          end else begin
            state_d = tgt_misaligned ? HALT : FETCH;
          end
        end
        DROP: begin
          halt_pend_d = tgt_misaligned;
          if (imem_ack_i) state_d = tgt_misaligned ? HALT : FETCH;
        end
        HALT:    state_d = tgt_misaligned ? HALT : FETCH;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (accept) pc_d = pc_q + 32'd4;
          if (stall_i) begin
            if (accept) begin
              pend_valid_d = 1'b1;
              pend_pc_d    = pc_q;
              pend_instr_d = imem_rdata_i;
            end
          end else if (pend_valid_q) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = pend_pc_q;
            ifid_instr_d = pend_instr_q;
            pend_valid_d = 1'b0;
          end else if (accept) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_rdata_i;
          end else begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
          end
        end
        DROP: begin
          if (imem_ack_i) state_d = halt_pend_q ? HALT : FETCH;
          if (!stall_i) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
          end
        end
        default: begin
          if (!stall_i) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drop_pc_q    <= 32'h0;
      halt_pend_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0;
      pend_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_pc_q    <= drop_pc_d;
      halt_pend_q  <= halt_pend_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      pend_instr_q <= pend_instr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32I core: holds the PC, issues requests to instruction memory, and drives the IF/ID pipeline register that supplies the instruction word and its opcode to the decode-stage control unit. It absorbs variable memory latency with a one-entry skid buffer, honours hazard-unit stalls, and discards in-flight fetches on branch/jump redirects.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset
- NOP_INSTR, 32'h0000_0013, word placed in IF/ID when empty/flushed (addi x0,x0,0)

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address; stable while imem_req_o high
- imem_ack_i  in  1  request complete this cycle; imem_rdata_i valid
- imem_rdata_i  in  32  instruction word
- stall_i  in  1  decode cannot accept; hold IF/ID
- redirect_i  in  1  branch/jump taken; flush and restart
- redirect_pc_i  in  32  new fetch PC
- if_id_valid_o  out  1  IF/ID holds a real instruction
- if_id_pc_o  out  32  PC of IF/ID instruction
- if_id_instr_o  out  32  instruction word
- if_id_opcode_o  out  7  if_id_instr_o[6:0], to control unit
- misalign_o  out  1  fetch halted on misaligned redirect (0 when feature compiled out)

## Operation
- Registers: fetch PC `pc`, state {FETCH, DROP, HALT}, skid buffer {pend_valid, pend_pc, pend_instr}, IF/ID {valid, pc, instr}.
- imem_req_o = (state==FETCH && !pend_valid) || state==DROP; imem_addr_o = pc in FETCH, the dropped address (`drop_pc`) in DROP.
- Protocol: once imem_req_o rises it stays high with a stable address until imem_ack_i; ack may arrive the same cycle as req (zero-wait). Ack while req low is ignored.
- FETCH, ack, no redirect: word tagged with pc; pc <= pc+4.
  - stall_i=0 and pend empty: IF/ID <= {1, pc, rdata}.
  - stall_i=1: pend <= {1, pc, rdata}; IF/ID holds.
- pend_valid and stall_i=0: IF/ID <= pend; pend cleared; req reasserts next cycle.
- stall_i=0 and nothing new: IF/ID valid <= 0, instr <= NOP_INSTR.
- redirect_i (priority over stall_i and ack): IF/ID valid <= 0, instr <= NOP_INSTR; pend cleared; pc <= redirect_pc_i.
  - If req high without ack this cycle: drop_pc <= current address, state <= DROP.
  - Otherwise state stays FETCH (the acked word is discarded).
- DROP: req held at drop_pc; on ack data discarded, state <= FETCH. Redirect in DROP only updates pc.
- if_id_opcode_o is always if_id_instr_o[6:0]; reads 7'b0010011 when empty.

## Timing
- Reset (rst_i high at edge): pc=RESET_PC, state=FETCH, pend_valid=0, IF/ID valid=0, pc=0, instr=NOP_INSTR, misalign_o=0. imem_req_o is high in the first cycle after reset is released, with addr=RESET_PC.
- Reset mid-transaction: outstanding request abandoned, no DROP; memory must tolerate this.
- Zero-wait memory, no stalls: one instruction per cycle; fetch-to-IF/ID latency 1 edge.
- Redirect: first request at the target issues the cycle after redirect (FETCH) or the cycle after the dropped ack (DROP).
- Stall release with pend full: IF/ID updates at that edge; next word is at least 1 cycle later.
- pc wraps modulo 2^32 (0xFFFF_FFFC+4 = 0).

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc_i[1:0]!=0 still flushes, but state <= HALT (after any DROP completes), misalign_o=1, req low. Only a new aligned redirect leaves HALT (clears misalign_o). A misaligned redirect in HALT stays in HALT.
- Undefined: redirect_pc_i[1:0] forced to 0; misalign_o tied 0; HALT unreachable.

## Test plan
- RESET_PC=0x100, zero-wait memory: addrs 0x100, 0x104, 0x108 on consecutive cycles; IF/ID pc follows one edge later with valid=1.
- stall_i high 3 cycles during zero-wait fetch of 0x108: pend holds 0x108, req low, IF/ID holds 0x104; on release IF/ID = 0x108, then 0x10C.
- 2-wait memory, redirect to 0x400 one cycle after req for 0x20: req stays at 0x20 until ack, data discarded, next req 0x400, IF/ID never valid with pc 0x20.
- redirect_i and stall_i together, pend full: IF/ID valid=0, instr=0x00000013, pend cleared, next req at target.
- FETCH_MISALIGN_TRAP_EN: redirect to 0x102 -> misalign_o=1, req low for 10 cycles; redirect to 0x200 -> misalign_o=0, req 0x200.
- rst_i asserted while a 3-wait request is outstanding: next cycle req=1, addr=RESET_PC, IF/ID valid=0.
